// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the 0x8000_00xx MMIO window.
// The execute-stage UART decode imports the same address constants.
package uart_mmio_responder_pkg;

    localparam logic [31:0] ADDR_CTRL = 32'h8000_0000;
    localparam logic [31:0] ADDR_RXD  = 32'h8000_0004;
    localparam logic [31:0] ADDR_TXD  = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYC  = 32'h8000_0010;
    localparam logic [31:0] ADDR_INS  = 32'h8000_0014;
    localparam logic [31:0] ADDR_RST  = 32'h8000_0018;
    localparam logic [31:0] ADDR_BCC  = 32'h8000_001c;
    localparam logic [31:0] ADDR_BCCS = 32'h8000_0020;

    typedef enum logic [3:0] {
        SEL_NONE = 4'd0,
        SEL_CTRL = 4'd1,
        SEL_RXD  = 4'd2,
        SEL_TXD  = 4'd3,
        SEL_CYC  = 4'd4,
        SEL_INS  = 4'd5,
        SEL_RST  = 4'd6,
        SEL_BCC  = 4'd7,
        SEL_BCCS = 4'd8
    } reg_sel_e;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_e;

    // Exact 32-bit match; anything else is a miss.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_CTRL: sel = SEL_CTRL;
            ADDR_RXD:  sel = SEL_RXD;
            ADDR_TXD:  sel = SEL_TXD;
            ADDR_CYC:  sel = SEL_CYC;
            ADDR_INS:  sel = SEL_INS;
            ADDR_RST:  sel = SEL_RST;
            ADDR_BCC:  sel = SEL_BCC;
            ADDR_BCCS: sel = SEL_BCCS;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_mmio_responder_rx_fifo.sv
// Synchronous FIFO for received UART bytes; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module mmio_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards any stored bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// MMIO responder for UART control/status, RX/TX data and performance counters.
// Load data is registered so it lines up with the synchronous DMEM read path.
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    input  logic        mmio_stall,
    input  logic        inst_retired,
    input  logic        br_retired,
    input  logic        br_correct,
    output logic [31:0] mmio_rdata,
    output logic        mmio_hit,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    reg_sel_e         sel_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             tx_wr_s;
    logic             ctrl_wr_s;
    logic             cnt_clr_s;
    logic             rx_push_s;
    logic             rx_pop_s;
    logic             rx_full_s;
    logic             rx_empty_s;
    logic [7:0]       rx_head_s;
    logic [31:0]      rd_val_s;
    logic             ovf_set_s;
    logic             wdata_unused_s;

    tx_state_e        tx_state_r;
    tx_state_e        tx_state_nxt_s;
    logic [7:0]       tx_data_r;
    logic [7:0]       tx_data_nxt_s;
    logic             tx_ovf_r;
    logic             tx_ovf_nxt_s;
    logic [31:0]      rdata_r;
    logic [CNT_W-1:0] cyc_r;
    logic [CNT_W-1:0] ins_r;
    logic [CNT_W-1:0] bcc_r;
    logic [CNT_W-1:0] bccs_r;

    assign sel_s          = decode_addr(mmio_addr);
    assign mmio_hit       = (sel_s != SEL_NONE);
    // A simultaneous load+store strobe is treated as a store only.
    assign wr_acc_s       = mmio_we & ~mmio_stall;
    assign rd_acc_s       = mmio_re & ~mmio_we & ~mmio_stall;
    assign tx_wr_s        = wr_acc_s & (sel_s == SEL_TXD);
    assign ctrl_wr_s      = wr_acc_s & (sel_s == SEL_CTRL);
    assign cnt_clr_s      = wr_acc_s & (sel_s == SEL_RST);
    assign rx_push_s      = uart_rx_valid & ~rx_full_s;
    assign rx_pop_s       = rd_acc_s & (sel_s == SEL_RXD) & ~rx_empty_s;
    assign uart_rx_ready  = ~rx_full_s;
    assign uart_tx_valid  = (tx_state_r == TX_FULL);
    assign uart_tx_data   = tx_data_r;
    assign mmio_rdata     = rdata_r;
    assign wdata_unused_s = ^mmio_wdata[31:8];

    mmio_rx_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .wdata (uart_rx_data),
        .head  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // TX buffer next-state: a write in the draining cycle reloads without a bubble.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_data_nxt_s  = tx_data_r;
        ovf_set_s      = 1'b0;
        case (tx_state_r)
            TX_EMPTY: begin
                if (tx_wr_s) begin
                    tx_state_nxt_s = TX_FULL;
                    tx_data_nxt_s  = mmio_wdata[7:0];
                end else begin
                    tx_state_nxt_s = TX_EMPTY;
                end
            end
            TX_FULL: begin
                if (tx_wr_s && uart_tx_ready) begin
                    tx_state_nxt_s = TX_FULL;
                    tx_data_nxt_s  = mmio_wdata[7:0];
                end else if (uart_tx_ready) begin
                    tx_state_nxt_s = TX_EMPTY;
                end else if (tx_wr_s) begin
                    ovf_set_s      = 1'b1;
                end else begin
                    tx_state_nxt_s = TX_FULL;
                end
            end
            default: begin
                tx_state_nxt_s = TX_EMPTY;
            end
        endcase
        if (ctrl_wr_s) begin
            tx_ovf_nxt_s = 1'b0;
        end else begin
            tx_ovf_nxt_s = tx_ovf_r | ovf_set_s;
        end
    end

    // Load data mux; write-only and unmapped addresses read as zero.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (sel_s)
            SEL_CTRL: rd_val_s = {29'b0, tx_ovf_r, ~rx_empty_s, (tx_state_r == TX_EMPTY)};
            SEL_RXD: begin
                if (!rx_empty_s) begin
                    rd_val_s = {24'b0, rx_head_s};
                end else begin
                    rd_val_s = 32'h0000_0000;
                end
            end
            SEL_CYC:  rd_val_s = 32'(cyc_r);
            SEL_INS:  rd_val_s = 32'(ins_r);
            SEL_BCC:  rd_val_s = 32'(bcc_r);
            SEL_BCCS: rd_val_s = 32'(bccs_r);
            default:  rd_val_s = 32'h0000_0000;
        endcase
    end

    // TX buffer, overflow flag and registered load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_EMPTY;
            tx_data_r  <= 8'h00;
            tx_ovf_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_ovf_r   <= tx_ovf_nxt_s;
            if (rd_acc_s) begin
                rdata_r <= rd_val_s;
            end
        end
    end

    // Performance counters; a counter-reset store wins over this cycle's increments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_r  <= '0;
            ins_r  <= '0;
            bcc_r  <= '0;
            bccs_r <= '0;
        end else if (cnt_clr_s) begin
            cyc_r  <= '0;
            ins_r  <= '0;
            bcc_r  <= '0;
            bccs_r <= '0;
        end else begin
            cyc_r  <= cyc_r + CNT_W'(1);
            ins_r  <= ins_r + CNT_W'(inst_retired);
            bcc_r  <= bcc_r + CNT_W'(br_retired);
            bccs_r <= bccs_r + CNT_W'(br_retired & br_correct);
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed self-checking bench for uart_mmio_responder, with a narrow-counter
// instance sharing all inputs to exercise counter wrap.
module tb_uart_mmio_responder;

    localparam logic [31:0] A_CTRL = 32'h8000_0000;
    localparam logic [31:0] A_RXD  = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INS  = 32'h8000_0014;
    localparam logic [31:0] A_RST  = 32'h8000_0018;
    localparam logic [31:0] A_BCC  = 32'h8000_001c;
    localparam logic [31:0] A_BCCS = 32'h8000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mmio_addr = 32'h0;
    logic [31:0] mmio_wdata = 32'h0;
    logic        mmio_we = 1'b0;
    logic        mmio_re = 1'b0;
    logic        mmio_stall = 1'b0;
    logic        inst_retired = 1'b0;
    logic        br_retired = 1'b0;
    logic        br_correct = 1'b0;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_valid = 1'b0;

    logic [31:0] mmio_rdata;
    logic        mmio_hit;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_rx_ready;

    logic [31:0] n_rdata;
    logic        n_hit;
    logic [7:0]  n_tx_data;
    logic        n_tx_valid;
    logic        n_rx_ready;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [31:0] rd;
    logic [4:0]  br_pat;

    always #5 clk = ~clk;

    uart_mmio_responder #(.RX_DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_stall(mmio_stall),
        .inst_retired(inst_retired), .br_retired(br_retired), .br_correct(br_correct),
        .mmio_rdata(mmio_rdata), .mmio_hit(mmio_hit), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    uart_mmio_responder #(.RX_DEPTH(8), .CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_stall(mmio_stall),
        .inst_retired(inst_retired), .br_retired(br_retired), .br_correct(br_correct),
        .mmio_rdata(n_rdata), .mmio_hit(n_hit), .uart_tx_data(n_tx_data),
        .uart_tx_valid(n_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(n_rx_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // All bus tasks start and end 1 ns after a rising edge.
    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_we    = 1'b1;
        @(posedge clk);
        #1;
        mmio_we    = 1'b0;
        mmio_addr  = 32'h0;
        mmio_wdata = 32'h0;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        mmio_addr = a;
        mmio_re   = 1'b1;
        @(posedge clk);
        #1;
        mmio_re   = 1'b0;
        mmio_addr = 32'h0;
        d = mmio_rdata;
    endtask

    task automatic rx_push(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Activity that the mid-run reset must discard
        mmio_write(A_TXD, 32'h77);
        rx_push(8'h11);
        rx_push(8'h22);
        mmio_read(A_CTRL, rd);
        check_eq("pre_reset_ctrl", rd, 32'h2);
        reset = 1'b0;
        #1;
        check_eq("rst_rdata", mmio_rdata, 32'h0);
        check_eq("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        check_eq("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mmio_read(A_CYC, rd);
        check_eq("rst_cyc", rd, 32'd3);
        check_eq("rst_cyc_n", n_rdata, 32'd3);
        mmio_read(A_INS, rd);
        check_eq("rst_ins", rd, 32'h0);
        mmio_read(A_BCC, rd);
        check_eq("rst_bcc", rd, 32'h0);
        mmio_read(A_BCCS, rd);
        check_eq("rst_bccs", rd, 32'h0);
        mmio_read(A_CTRL, rd);
        check_eq("rst_ctrl", rd, 32'h1);

        // TX overflow while the serializer is stalled
        mmio_write(A_TXD, 32'h41);
        check_eq("tx_valid_1", {31'b0, uart_tx_valid}, 32'h1);
        check_eq("tx_data_1", {24'b0, uart_tx_data}, 32'h41);
        mmio_write(A_TXD, 32'h42);
        check_eq("tx_data_kept", {24'b0, uart_tx_data}, 32'h41);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_ovf", rd, 32'h4);
        mmio_write(A_CTRL, 32'h0);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_ovf_clr", rd, 32'h0);
        uart_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        uart_tx_ready = 1'b0;
        check_eq("tx_drained", {31'b0, uart_tx_valid}, 32'h0);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_after_drain", rd, 32'h1);

        // Write in the draining cycle reloads without a drop
        mmio_write(A_TXD, 32'h55);
        uart_tx_ready = 1'b1;
        mmio_write(A_TXD, 32'h66);
        uart_tx_ready = 1'b0;
        check_eq("b2b_valid", {31'b0, uart_tx_valid}, 32'h1);
        check_eq("b2b_data", {24'b0, uart_tx_data}, 32'h66);
        mmio_read(A_CTRL, rd);
        check_eq("b2b_no_ovf", rd, 32'h0);
        uart_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        uart_tx_ready = 1'b0;

        // Fill the RX FIFO, then drain it completely
        for (int i = 0; i < 8; i++) begin
            rx_push(8'h10 + 8'(i));
        end
        check_eq("rx_full_ready", {31'b0, uart_rx_ready}, 32'h0);
        rx_push(8'h99);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_rx_nonempty", rd, 32'h3);
        for (int i = 0; i < 8; i++) begin
            mmio_read(A_RXD, rd);
            check_eq($sformatf("rxd_%0d", i), rd, 32'h10 + 32'(i));
        end
        mmio_read(A_RXD, rd);
        check_eq("rxd_empty", rd, 32'h0);
        check_eq("rx_ready_again", {31'b0, uart_rx_ready}, 32'h1);

        // Stalled RXD read neither pops nor updates rdata
        rx_push(8'hA5);
        rx_push(8'hB6);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_before_stall", rd, 32'h3);
        mmio_addr  = A_RXD;
        mmio_re    = 1'b1;
        mmio_stall = 1'b1;
        @(posedge clk);
        #1;
        mmio_re    = 1'b0;
        mmio_stall = 1'b0;
        mmio_addr  = 32'h0;
        check_eq("stall_rdata", mmio_rdata, 32'h3);
        mmio_read(A_RXD, rd);
        check_eq("rxd_after_stall", rd, 32'hA5);
        mmio_read(A_RXD, rd);
        check_eq("rxd_second", rd, 32'hB6);
        mmio_read(A_CTRL, rd);
        check_eq("ctrl_fifo_drained", rd, 32'h1);

        // Address decode and misses
        mmio_addr = 32'h8000_0024;
        #1;
        check_eq("hit_above_map", {31'b0, mmio_hit}, 32'h0);
        mmio_addr = A_BCCS;
        #1;
        check_eq("hit_bccs", {31'b0, mmio_hit}, 32'h1);
        mmio_addr = 32'h8000_000c;
        #1;
        check_eq("hit_hole", {31'b0, mmio_hit}, 32'h0);
        mmio_read(32'h8000_000c, rd);
        check_eq("miss_read", rd, 32'h0);
        mmio_write(32'h8000_0009, 32'h12);
        check_eq("miss_write", {31'b0, uart_tx_valid}, 32'h0);

        // Branch / instruction counters and counter-reset priority
        mmio_write(A_RST, 32'h0);
        br_pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            br_retired = 1'b1;
            br_correct = br_pat[i];
            @(posedge clk);
            #1;
        end
        br_retired = 1'b0;
        br_correct = 1'b0;
        inst_retired = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inst_retired = 1'b0;
        mmio_read(A_BCC, rd);
        check_eq("bcc", rd, 32'd5);
        mmio_read(A_BCCS, rd);
        check_eq("bccs", rd, 32'd3);
        mmio_read(A_INS, rd);
        check_eq("ins", rd, 32'd2);
        inst_retired = 1'b1;
        mmio_write(A_RST, 32'h0);
        inst_retired = 1'b0;
        mmio_read(A_CYC, rd);
        check_eq("cyc_after_rst", rd, 32'h0);
        mmio_read(A_INS, rd);
        check_eq("ins_rst_priority", rd, 32'h0);
        mmio_read(A_BCC, rd);
        check_eq("bcc_after_rst", rd, 32'h0);

        // Counter wrap on the 4-bit build
        mmio_write(A_RST, 32'h0);
        repeat (15) @(posedge clk);
        #1;
        mmio_read(A_CYC, rd);
        check_eq("cyc_15", rd, 32'd15);
        check_eq("cyc_n_15", n_rdata, 32'd15);
        mmio_read(A_CYC, rd);
        check_eq("cyc_16", rd, 32'd16);
        check_eq("cyc_n_wrap", n_rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
